uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter GAP_CYCLES, default 16, idle clocks forced between consecutive frames.
REQ-003 Parameter START_TIMEOUT, default 255, max clocks from txStart to txBusy high.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rstN  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_REQ  requester i has a byte pending.
REQ-007 reqData  in  NUM_REQ*8  byte for requester i at bits [8i+7:8i].
REQ-008 ack  out  NUM_REQ  one-clock pulse: byte i captured.
REQ-009 done  out  NUM_REQ  one-clock pulse: byte i fully transmitted.
REQ-010 txEn  out  1  transmitter enable to Uart8.
REQ-011 txStart  out  1  start request to Uart8.
REQ-012 txByte  out  8  byte presented to Uart8.
REQ-013 txBusy  in  1  Uart8 transmitter busy.
REQ-014 txDone  in  1  Uart8 transmission-complete pulse.
REQ-015 grantId  out  clog2(NUM_REQ)  index of current owner.
REQ-016 active  out  1  high in every state except IDLE.
REQ-017 err  out  1  one-clock pulse on start timeout.

Function
REQ-018 States IDLE, START, WAIT_BUSY, WAIT_DONE, GAP; encoding fixed in package.
REQ-019 IDLE: if any req, pick winner round-robin from pointer ptr, register reqData slice to txByte, set grantId, pulse ack[winner], go START next clock.
REQ-020 Round-robin: search indices ptr, ptr+1, ... wrapping modulo NUM_REQ; first asserted wins; ptr=0 after reset.
REQ-021 On each grant ptr SHALL become (winner+1) mod NUM_REQ, including wrap from NUM_REQ-1 to 0.
REQ-022 START: assert txStart exactly one clock, go WAIT_BUSY.
REQ-023 WAIT_BUSY: txBusy high -> WAIT_DONE; timeout counter reaching START_TIMEOUT -> pulse err, no done, go GAP.
REQ-024 WAIT_DONE: txDone high -> pulse done[grantId] same clock as transition, go GAP.
REQ-025 GAP: count GAP_CYCLES clocks, then IDLE; GAP_CYCLES=0 -> IDLE next clock.
REQ-026 Latency req-to-ack 1 clock from IDLE; ack-to-txStart 1 clock.
REQ-027 txByte and grantId SHALL stay stable from ack until next grant.
REQ-028 req sampled only in IDLE; changes to req or reqData after ack have no effect on current frame.
REQ-029 txDone arriving in WAIT_BUSY (txBusy missed) SHALL be treated as completion: done pulse, go GAP.
REQ-030 txDone/txBusy in IDLE, START or GAP SHALL be ignored.
REQ-031 txEn SHALL be 1 whenever rstN is high.
REQ-032 At most one ack bit and one done bit high per clock.

Reset
REQ-033 rstN low SHALL immediately force state IDLE, ptr=0, counters 0, txStart=0, txEn=0, txByte=0, grantId=0, ack=0, done=0, active=0, err=0.
REQ-034 Reset mid-frame SHALL abandon the frame with no done or err pulse.
REQ-035 First grant SHALL occur no earlier than the second rising edge after rstN deasserts.

Structure
REQ-036 Package uart_arb_pkg SHALL hold state enum, counter widths and default parameter constants.
REQ-037 Round-robin selection SHALL be sub-module rr_pick (req, ptr -> valid, winner), purely combinational.
REQ-038 Counters (gap, timeout) SHALL share one down-counter in the top module.

Verification
REQ-039 req=4'b0001, data0=8'h55, Uart8 model busy 10 clocks -> ack[0] +1 clk, txStart +2 clk, txByte=8'h55, done[0] on txDone.
REQ-040 req=4'b1111 held -> grant order 0,1,2,3,0 with GAP_CYCLES idle between frames.
REQ-041 ptr=3 after grant 2, req=4'b0101 -> winner 0 (wrap), then 2.
REQ-042 txBusy never asserted -> err pulse START_TIMEOUT clocks after txStart, no done, next req served.
REQ-043 rstN low during WAIT_DONE -> all outputs 0 same edge, no done; after release req=4'b0010 granted normally.
REQ-044 txDone without txBusy in WAIT_BUSY -> done[grantId] pulse, GAP entered.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } arbState_e;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_GAP_CYCLES    = 16;
  localparam int DEF_START_TIMEOUT = 255;

  // Shared gap/timeout down-counter width; both limits must fit.
  localparam int CNT_W = 16;

  // A wait of N clocks ends when the counter, loaded with N-1, reaches zero.
  function automatic logic [CNT_W-1:0] cntLoad(input int unsigned cycles);
    return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int unsigned NR = NUM_REQ;

  // Scan from ptr upward with wraparound; the first hit wins.
  always_comb begin
    logic [PW-1:0] idx;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = PW'((32'(ptr) + i) % NR);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one Uart8 transmitter among NUM_REQ byte sources.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       reqData,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic                       txEn,
  output logic                       txStart,
  output logic [7:0]                 txByte,
  input  logic                       txBusy,
  input  logic                       txDone,
  output logic [$clog2(NUM_REQ)-1:0] grantId,
  output logic                       active,
  output logic                       err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0]    LAST         = PW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = cntLoad(START_TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LOAD     = cntLoad(GAP_CYCLES);

  arbState_e          state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [PW-1:0]      ptr, ptrNext;
  logic               armed;
  logic [7:0]         txByteNext;
  logic [PW-1:0]      grantIdNext;
  logic [NUM_REQ-1:0] ackNext, doneNext;
  logic               errNext, txStartNext;

  logic               pickValid;
  logic [PW-1:0]      pickWinner;
  logic [7:0]         pickByte;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) uPick (
    .req   (req),
    .ptr   (ptr),
    .valid (pickValid),
    .winner(pickWinner)
  );

  // Select the winning requester's byte lane.
  always_comb begin
    pickByte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pickWinner == PW'(i)) pickByte = reqData[8*i +: 8];
    end
  end

  // Transmitter is enabled for as long as the block is out of reset.
  assign txEn   = rstN;
  assign active = (state != ST_IDLE);

  // Next-state and registered-output logic; all outputs are pulses or holds.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    ptrNext     = ptr;
    txByteNext  = txByte;
    grantIdNext = grantId;
    ackNext     = '0;
    doneNext    = '0;
    errNext     = 1'b0;
    txStartNext = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (armed && pickValid) begin
          ackNext     = NUM_REQ'(1) << pickWinner;
          txByteNext  = pickByte;
          grantIdNext = pickWinner;
          ptrNext     = (pickWinner == LAST) ? '0 : pickWinner + PW'(1);
          stateNext   = ST_START;
        end
      end
      ST_START: begin
        txStartNext = 1'b1;
        cntNext     = TIMEOUT_LOAD;
        stateNext   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A completion that arrives without a visible busy phase still counts.
        if (txDone) begin
          doneNext  = NUM_REQ'(1) << grantId;
          cntNext   = GAP_LOAD;
          stateNext = ST_GAP;
        end else if (txBusy) begin
          stateNext = ST_WAIT_DONE;
        end else if (cnt == '0) begin
          errNext   = 1'b1;
          cntNext   = GAP_LOAD;
          stateNext = ST_GAP;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (txDone) begin
          doneNext  = NUM_REQ'(1) << grantId;
          cntNext   = GAP_LOAD;
          stateNext = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt == '0) stateNext = ST_IDLE;
        else           cntNext   = cnt - CNT_W'(1);
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State and output registers; armed holds off grants for the first edge after reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      armed   <= 1'b0;
      txByte  <= '0;
      grantId <= '0;
      ack     <= '0;
      done    <= '0;
      err     <= 1'b0;
      txStart <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      ptr     <= ptrNext;
      armed   <= 1'b1;
      txByte  <= txByteNext;
      grantId <= grantIdNext;
      ack     <= ackNext;
      done    <= doneNext;
      err     <= errNext;
      txStart <= txStartNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural Uart8 model.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int GAP = 5;
  localparam int STO = 20;

  localparam int W_ACK = 0, W_START = 1, W_DONE = 2, W_ERR = 3, W_IDLE = 4;
  localparam int M_NORMAL = 0, M_DONEONLY = 1, M_NONE = 2;

  logic            clk;
  logic            rstN;
  logic [NR-1:0]   req;
  logic [NR*8-1:0] reqData;
  logic [NR-1:0]   ack, done;
  logic            txEn, txStart, txBusy, txDone, active, err;
  logic [7:0]      txByte;
  logic [1:0]      grantId;

  int nCmp = 0;
  int nFail = 0;
  int modelPtr = 0;
  int uMode = M_NORMAL;
  int uCnt = 0;
  bit inject = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .GAP_CYCLES(GAP),
    .START_TIMEOUT(STO)
  ) dut (
    .clk(clk), .rstN(rstN), .req(req), .reqData(reqData), .ack(ack), .done(done),
    .txEn(txEn), .txStart(txStart), .txByte(txByte), .txBusy(txBusy), .txDone(txDone),
    .grantId(grantId), .active(active), .err(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Uart8 model: normal = busy for 10 clocks then txDone; doneOnly = txDone after 3 clocks, no busy.
  initial begin
    txBusy = 0;
    txDone = 0;
  end
  always @(negedge clk) begin
    txDone = 0;
    if (!rstN) begin
      uCnt = 0;
      txBusy = 0;
    end else if (uCnt > 0) begin
      uCnt--;
      if (uCnt == 0) begin
        txBusy = 0;
        txDone = 1;
      end
    end else if (txStart && uMode == M_NORMAL) begin
      txBusy = 1;
      uCnt = 10;
    end else if (txStart && uMode == M_DONEONLY) begin
      uCnt = 3;
    end else if (inject) begin
      txBusy = 1;
      txDone = 1;
    end else begin
      txBusy = 0;
    end
  end

  // Round-robin rule: first requester at or after p, wrapping.
  function automatic int rrModel(input int p, input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  // Advance negedge by negedge until the chosen event shows; n = cycles taken or -1.
  task automatic waitSig(input int which, input int limit, output int n, output bit sawDone);
    bit hit;
    n = 0;
    sawDone = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (done != 0) sawDone = 1;
      case (which)
        W_ACK:   hit = (ack != 0);
        W_START: hit = txStart;
        W_DONE:  hit = (done != 0);
        W_ERR:   hit = err;
        default: hit = !active;
      endcase
      if (hit) return;
    end
    n = -1;
  endtask

  task automatic test_reset;
    int n;
    bit sd;
    rstN = 1; req = 0; reqData = 0;
    #2 rstN = 0;
    repeat (3) @(negedge clk);
    nCmp++;
    if ({ack, done, txStart, txEn, txByte, grantId, active, err} !== 22'd0) begin
      nFail++;
      $display("FAIL reset_outputs: got %h want 0", {ack, done, txStart, txEn, txByte, grantId, active, err});
    end
    rstN = 1; req = 4'b0001; reqData[7:0] = 8'hA5; modelPtr = 0;
    #1;
    nCmp++; if (txEn !== 1'b1) begin nFail++; $display("FAIL reset_txEn: got %b want 1", txEn); end
    waitSig(W_ACK, 10, n, sd);
    nCmp++; if (n !== 2) begin nFail++; $display("FAIL reset_first_grant: got %0d want 2", n); end
    nCmp++; if (ack !== 4'b0001) begin nFail++; $display("FAIL reset_ack: got %b want 0001", ack); end
    req = 0; modelPtr = 1;
    waitSig(W_IDLE, 60, n, sd);
    nCmp++; if (n < 0) begin nFail++; $display("FAIL reset_idle: got timeout want idle"); end
  endtask

  task automatic test_single;
    int n;
    bit sd;
    req = 4'b0001; reqData[7:0] = 8'h55;
    waitSig(W_ACK, GAP + 10, n, sd);
    nCmp++; if (n !== 1) begin nFail++; $display("FAIL single_ack_lat: got %0d want 1", n); end
    nCmp++; if (ack !== 4'b0001) begin nFail++; $display("FAIL single_ack: got %b want 0001", ack); end
    nCmp++; if (txByte !== 8'h55) begin nFail++; $display("FAIL single_byte: got %h want 55", txByte); end
    req = 0; reqData[7:0] = 8'hAA;
    waitSig(W_START, 5, n, sd);
    nCmp++; if (n !== 1) begin nFail++; $display("FAIL single_start_lat: got %0d want 1", n); end
    waitSig(W_DONE, 40, n, sd);
    nCmp++; if (n !== 11) begin nFail++; $display("FAIL single_done_lat: got %0d want 11", n); end
    nCmp++; if (done !== 4'b0001) begin nFail++; $display("FAIL single_done: got %b want 0001", done); end
    nCmp++; if (txByte !== 8'h55) begin nFail++; $display("FAIL single_byte_hold: got %h want 55", txByte); end
    waitSig(W_IDLE, GAP + 10, n, sd);
    nCmp++; if (n !== GAP) begin nFail++; $display("FAIL single_gap: got %0d want %0d", n, GAP); end
    modelPtr = 1;
  endtask

  task automatic test_round_robin;
    int n, exp;
    bit sd;
    rstN = 0;
    @(negedge clk);
    rstN = 1; req = 4'b1111; reqData = 32'($urandom); modelPtr = 0;
    for (int k = 0; k < 5; k++) begin
      exp = rrModel(modelPtr, req);
      waitSig(W_ACK, GAP + 10, n, sd);
      nCmp++;
      if (n !== ((k == 0) ? 2 : GAP + 1)) begin
        nFail++; $display("FAIL rr_ack_lat%0d: got %0d want %0d", k, n, (k == 0) ? 2 : GAP + 1);
      end
      nCmp++; if (grantId !== 2'(exp)) begin nFail++; $display("FAIL rr_grant%0d: got %0d want %0d", k, grantId, exp); end
      nCmp++;
      if (txByte !== reqData[8*exp +: 8]) begin
        nFail++; $display("FAIL rr_byte%0d: got %h want %h", k, txByte, reqData[8*exp +: 8]);
      end
      modelPtr = (exp + 1) % NR;
      waitSig(W_DONE, 40, n, sd);
      nCmp++; if (done !== 4'(1 << exp)) begin nFail++; $display("FAIL rr_done%0d: got %b want %0d", k, done, exp); end
    end
    req = 0;
    waitSig(W_IDLE, GAP + 10, n, sd);
  endtask

  task automatic test_wrap;
    int n, exp;
    bit sd;
    req = 4'b0100;
    waitSig(W_ACK, GAP + 10, n, sd);
    nCmp++; if (grantId !== 2'd2) begin nFail++; $display("FAIL wrap_pre: got %0d want 2", grantId); end
    modelPtr = 3;
    req = 0;
    waitSig(W_DONE, 40, n, sd);
    waitSig(W_IDLE, GAP + 10, n, sd);
    req = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      exp = rrModel(modelPtr, req);
      waitSig(W_ACK, GAP + 10, n, sd);
      nCmp++; if (grantId !== 2'(exp)) begin nFail++; $display("FAIL wrap_grant%0d: got %0d want %0d", k, grantId, exp); end
      modelPtr = (exp + 1) % NR;
      waitSig(W_DONE, 40, n, sd);
    end
    req = 0;
    waitSig(W_IDLE, GAP + 10, n, sd);
  endtask

  task automatic test_timeout;
    int n, exp;
    bit sd;
    uMode = M_NONE; req = 4'b0010;
    exp = rrModel(modelPtr, req);
    waitSig(W_ACK, GAP + 10, n, sd);
    nCmp++; if (grantId !== 2'(exp)) begin nFail++; $display("FAIL to_grant: got %0d want %0d", grantId, exp); end
    modelPtr = (exp + 1) % NR;
    req = 0;
    waitSig(W_START, 5, n, sd);
    waitSig(W_ERR, STO + 10, n, sd);
    nCmp++; if (n !== STO) begin nFail++; $display("FAIL to_err_lat: got %0d want %0d", n, STO); end
    nCmp++; if (sd !== 1'b0) begin nFail++; $display("FAIL to_no_done: got %b want 0", sd); end
    uMode = M_NORMAL; req = 4'b1000;
    exp = rrModel(modelPtr, req);
    waitSig(W_ACK, GAP + 10, n, sd);
    nCmp++; if (n !== GAP + 1) begin nFail++; $display("FAIL to_next_lat: got %0d want %0d", n, GAP + 1); end
    nCmp++; if (grantId !== 2'(exp)) begin nFail++; $display("FAIL to_next_grant: got %0d want %0d", grantId, exp); end
    modelPtr = (exp + 1) % NR;
    req = 0;
    waitSig(W_DONE, 40, n, sd);
    waitSig(W_IDLE, GAP + 10, n, sd);
  endtask

  task automatic test_done_no_busy;
    int n, exp;
    bit sd;
    uMode = M_DONEONLY; req = 4'b0100;
    exp = rrModel(modelPtr, req);
    waitSig(W_ACK, GAP + 10, n, sd);
    modelPtr = (exp + 1) % NR;
    req = 0;
    waitSig(W_START, 5, n, sd);
    waitSig(W_DONE, 20, n, sd);
    nCmp++; if (n !== 4) begin nFail++; $display("FAIL nb_done_lat: got %0d want 4", n); end
    nCmp++; if (done !== 4'(1 << exp)) begin nFail++; $display("FAIL nb_done: got %b want bit %0d", done, exp); end
    waitSig(W_IDLE, GAP + 10, n, sd);
    nCmp++; if (n !== GAP) begin nFail++; $display("FAIL nb_gap: got %0d want %0d", n, GAP); end
    uMode = M_NORMAL;
  endtask

  task automatic test_reset_mid;
    int n;
    bit sd, bad;
    req = 4'b0001;
    waitSig(W_ACK, GAP + 10, n, sd);
    req = 0;
    waitSig(W_START, 5, n, sd);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rstN = 0;
    #1;
    nCmp++;
    if ({ack, done, txStart, txEn, txByte, grantId, active, err} !== 22'd0) begin
      nFail++;
      $display("FAIL mid_reset_outputs: got %h want 0", {ack, done, txStart, txEn, txByte, grantId, active, err});
    end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done != 0 || err) bad = 1;
    end
    nCmp++; if (bad !== 1'b0) begin nFail++; $display("FAIL mid_reset_pulse: got %b want 0", bad); end
    rstN = 1; req = 4'b0010; modelPtr = 0;
    waitSig(W_ACK, 10, n, sd);
    nCmp++; if (n !== 2) begin nFail++; $display("FAIL mid_regrant_lat: got %0d want 2", n); end
    nCmp++; if (ack !== 4'b0010) begin nFail++; $display("FAIL mid_regrant: got %b want 0010", ack); end
    modelPtr = 2;
    req = 0;
    waitSig(W_DONE, 40, n, sd);
    nCmp++; if (done !== 4'b0010) begin nFail++; $display("FAIL mid_done: got %b want 0010", done); end
    waitSig(W_IDLE, GAP + 10, n, sd);
  endtask

  task automatic test_ignore;
    int n;
    bit sd, bad;
    bad = 0;
    inject = 1;
    repeat (3) begin
      @(negedge clk);
      if (done != 0 || err || active || ack != 0) bad = 1;
    end
    inject = 0;
    nCmp++; if (bad !== 1'b0) begin nFail++; $display("FAIL ign_idle: got %b want 0", bad); end
    req = 4'b1000;
    waitSig(W_ACK, GAP + 10, n, sd);
    modelPtr = 0;
    req = 0;
    waitSig(W_DONE, 40, n, sd);
    bad = 0;
    inject = 1;
    repeat (GAP - 1) begin
      @(negedge clk);
      if (done != 0 || err || !active) bad = 1;
    end
    inject = 0;
    nCmp++; if (bad !== 1'b0) begin nFail++; $display("FAIL ign_gap: got %b want 0", bad); end
    waitSig(W_IDLE, GAP + 10, n, sd);
    nCmp++; if (n !== 1) begin nFail++; $display("FAIL ign_gap_len: got %0d want 1", n); end
  endtask

  task automatic test_random;
    int n, exp;
    bit sd;
    logic [NR-1:0] r;
    logic [7:0] want;
    for (int it = 0; it < 25; it++) begin
      uMode = int'($urandom_range(0, 1));
      r = NR'($urandom_range(1, (1 << NR) - 1));
      req = r; reqData = 32'($urandom);
      exp = rrModel(modelPtr, r);
      want = reqData[8*exp +: 8];
      waitSig(W_ACK, GAP + 10, n, sd);
      nCmp++; if (n !== 1) begin nFail++; $display("FAIL rnd_lat%0d: got %0d want 1", it, n); end
      nCmp++; if (ack !== 4'(1 << exp)) begin nFail++; $display("FAIL rnd_ack%0d: got %b want bit %0d", it, ack, exp); end
      nCmp++; if (txByte !== want) begin nFail++; $display("FAIL rnd_byte%0d: got %h want %h", it, txByte, want); end
      modelPtr = (exp + 1) % NR;
      req = NR'($urandom); reqData = 32'($urandom);
      waitSig(W_DONE, 40, n, sd);
      req = 0;
      nCmp++; if (done !== 4'(1 << exp)) begin nFail++; $display("FAIL rnd_done%0d: got %b want bit %0d", it, done, exp); end
      nCmp++; if (txByte !== want) begin nFail++; $display("FAIL rnd_hold%0d: got %h want %h", it, txByte, want); end
      waitSig(W_IDLE, GAP + 10, n, sd);
      nCmp++; if (n < 0) begin nFail++; $display("FAIL rnd_idle%0d: got timeout want idle", it); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_done_no_busy();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
